multicycle_ctrl: RTL and testbench

- Multi-cycle control FSM for the RV32I lab core.
- Sequences fetch, decode, execute, memory and writeback for R-type, I-ALU, LW, SW, BEQ and BNE.
- Drives register-file, memory, PC and IR enables, plus ALU, immediate and writeback selects.
- Takes opcode/funct3 from the IR fields consumed by the instruction decoder, and the ALU zero flag from the datapath.

---
 rtl/multicycle_ctrl_if.sv | 36 +++
 rtl/multicycle_ctrl.sv | 163 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control/datapath bundle for the RV32I multi-cycle controller.
// master: the controller (reads IR fields and flags, drives enables/selects).
// slave:  the datapath side (drives IR fields and flags, consumes enables).
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             zero;
  logic             mem_ready;
  logic             mem_re;
  logic             mem_we;
  logic             ir_we;
  logic             pc_we;
  logic             pc_src;
  logic             reg_we;
  logic             alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       imm_sel;
  logic             wb_sel;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired;
  logic             illegal;

  modport master (
    input  opcode, funct3, zero, mem_ready,
    output mem_re, mem_we, ir_we, pc_we, pc_src, reg_we, alu_src_b,
           alu_op, imm_sel, wb_sel, state, retired, illegal
  );

  modport slave (
    output opcode, funct3, zero, mem_ready,
    input  mem_re, mem_we, ir_we, pc_we, pc_src, reg_we, alu_src_b,
           alu_op, imm_sel, wb_sel, state, retired, illegal
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I lab core: FETCH, DECODE, EXEC, MEM,
// WB for R-type, I-ALU, LW, SW, BEQ and BNE.
// Optional macro MULTICYCLE_CTRL_ILLEGAL_TRAP_EN: an illegal opcode enters an
// absorbing TRAP state and raises illegal; otherwise it retires as a NOP.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  multicycle_ctrl_if.master bus
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic             illegal_q;
  logic             retire, trap_set;
  logic             legal, taken;
  logic [1:0]       imm_dec;

  logic             mem_re, mem_we, ir_we, pc_we, pc_src, reg_we, alu_src_b, wb_sel;
  logic [1:0]       alu_op, imm_sel;

  // Opcode legality, immediate format and branch condition from the IR fields.
  always_comb begin
    legal   = 1'b0;
    imm_dec = 2'b00;
    unique case (bus.opcode)
      OP_R, OP_I, OP_LW: legal = 1'b1;
      OP_SW:     begin legal = 1'b1; imm_dec = 2'b01; end
      OP_BRANCH: begin legal = 1'b1; imm_dec = 2'b10; end
      default:   legal = 1'b0;
    endcase
    taken = ((bus.funct3 == 3'b000) &&  bus.zero) ||
            ((bus.funct3 == 3'b001) && !bus.zero);
  end

  // Next state, retire strobe and control outputs for the current state.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    retire    = 1'b0;
    trap_set  = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 1'b0;
    reg_we    = 1'b0;
    alu_src_b = 1'b0;
    alu_op    = 2'b00;
    imm_sel   = 2'b00;
    wb_sel    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        mem_re = 1'b1;
        if (bus.mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        imm_sel = imm_dec;
        if (legal) begin
          state_d = S_EXEC;
        end else begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
          state_d  = S_TRAP;
          trap_set = 1'b1;
`else
          state_d = S_FETCH;
          retire  = 1'b1;
`endif
        end
      end
      S_EXEC: begin
        imm_sel = imm_dec;
        unique case (bus.opcode)
          OP_R:  begin alu_op = 2'b10; state_d = S_WB; end
          OP_I:  begin alu_src_b = 1'b1; alu_op = 2'b10; state_d = S_WB; end
          OP_LW, OP_SW: begin alu_src_b = 1'b1; state_d = S_MEM; end
          OP_BRANCH: begin
            alu_op  = 2'b01;
            pc_we   = taken;
            pc_src  = taken;
            state_d = S_FETCH;
            retire  = 1'b1;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        // Address operands stay selected so the effective address is stable.
        imm_sel   = imm_dec;
        alu_src_b = 1'b1;
        if (bus.opcode == OP_LW) begin
          mem_re = 1'b1;
          if (bus.mem_ready) state_d = S_WB;
        end else begin
          mem_we = 1'b1;
          if (bus.mem_ready) begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        end
      end
      S_WB: begin
        reg_we  = 1'b1;
        wb_sel  = (bus.opcode == OP_LW);
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // State, retired counter and sticky illegal flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      if (retire) retired_q <= retired_q + CNT_W'(1);
      if (trap_set) illegal_q <= 1'b1;
    end
  end

  // Combinational controls are forced low while reset is held, since FETCH
  // would otherwise request a memory read during reset.
  assign bus.mem_re    = rst_n & mem_re;
  assign bus.mem_we    = rst_n & mem_we;
  assign bus.ir_we     = rst_n & ir_we;
  assign bus.pc_we     = rst_n & pc_we;
  assign bus.pc_src    = rst_n & pc_src;
  assign bus.reg_we    = rst_n & reg_we;
  assign bus.alu_src_b = rst_n & alu_src_b;
  assign bus.alu_op    = rst_n ? alu_op  : 2'b00;
  assign bus.imm_sel   = rst_n ? imm_sel : 2'b00;
  assign bus.wb_sel    = rst_n & wb_sel;
  assign bus.state     = state_q;
  assign bus.retired   = retired_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the stimulus process drives one cycle
// of inputs and queues the hand-derived outputs for that cycle; a monitor on
// the falling edge pops and compares.
module tb_multicycle_ctrl;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  typedef struct packed {
    logic [2:0]  st;
    logic        mem_re, mem_we, ir_we, pc_we, pc_src, reg_we, alu_src_b;
    logic [1:0]  alu_op, imm_sel;
    logic        wb_sel, illegal;
    logic [31:0] retired;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  multicycle_ctrl_if #(.CNT_W(32)) bus ();

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  obs_t  exp_q[$];
  string nm_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  logic [6:0] cur_op = '0;
  logic [2:0] cur_f3 = '0;
  int    ret = 0;

  // en = {mem_re, mem_we, ir_we, pc_we, pc_src, reg_we, alu_src_b}
  function automatic obs_t mk(input logic [2:0] st, input logic [6:0] en,
                              input logic [1:0] aop, input logic [1:0] isel,
                              input logic wb, input logic ill, input int r);
    obs_t o;
    o.st = st;
    {o.mem_re, o.mem_we, o.ir_we, o.pc_we, o.pc_src, o.reg_we, o.alu_src_b} = en;
    o.alu_op = aop; o.imm_sel = isel; o.wb_sel = wb; o.illegal = ill;
    o.retired = r;
    return o;
  endfunction

  // Fields that are defined for the expected state; the rest are ignored.
  function automatic obs_t care(input obs_t e);
    obs_t m = '0;
    m.st = '1; m.retired = '1; m.illegal = 1'b1;
    m.mem_re = 1'b1; m.mem_we = 1'b1; m.ir_we = 1'b1; m.pc_we = 1'b1; m.reg_we = 1'b1;
    if (e.pc_we) m.pc_src = 1'b1;
    if (e.st == S_EXEC) begin m.alu_src_b = 1'b1; m.alu_op = '1; end
    if (e.st == S_DECODE || e.st == S_EXEC) m.imm_sel = '1;
    if (e.st == S_WB) m.wb_sel = 1'b1;
    return m;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.st = bus.state; o.mem_re = bus.mem_re; o.mem_we = bus.mem_we;
    o.ir_we = bus.ir_we; o.pc_we = bus.pc_we; o.pc_src = bus.pc_src;
    o.reg_we = bus.reg_we; o.alu_src_b = bus.alu_src_b; o.alu_op = bus.alu_op;
    o.imm_sel = bus.imm_sel; o.wb_sel = bus.wb_sel; o.illegal = bus.illegal;
    o.retired = bus.retired;
    return o;
  endfunction

  task automatic check(input string nm, input obs_t act, input obs_t req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got st=%0d en=%b alu=%b imm=%b wb=%b ill=%b ret=%0d, required st=%0d en=%b alu=%b imm=%b wb=%b ill=%b ret=%0d",
                  nm, act.st,
                  {act.mem_re, act.mem_we, act.ir_we, act.pc_we, act.pc_src, act.reg_we, act.alu_src_b},
                  act.alu_op, act.imm_sel, act.wb_sel, act.illegal, act.retired,
                  req.st,
                  {req.mem_re, req.mem_we, req.ir_we, req.pc_we, req.pc_src, req.reg_we, req.alu_src_b},
                  req.alu_op, req.imm_sel, req.wb_sel, req.illegal, req.retired);
  endtask

  // One cycle: drive inputs just after the rising edge and queue the outputs
  // that must be visible for the rest of that cycle.
  task automatic step(input logic r, input logic z, input logic rdy,
                      input obs_t e, input string nm);
    @(posedge clk);
    #1;
    rst_n         = r;
    bus.opcode    = cur_op;
    bus.funct3    = cur_f3;
    bus.zero      = z;
    bus.mem_ready = rdy;
    exp_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  // Common FETCH and DECODE cycles of every instruction.
  task automatic fetch_decode(input logic [1:0] isel, input string nm);
    step(1, 0, 1, mk(S_FETCH, 7'b1011000, 2'b00, 2'b00, 0, 0, ret), {nm, "_fetch"});
    step(1, 0, 0, mk(S_DECODE, 7'b0, 2'b00, isel, 0, 0, ret), {nm, "_decode"});
  endtask

  // Branch: FETCH, DECODE, EXEC, retiring at the end of EXEC.
  task automatic branch(input logic [2:0] f3, input logic z, input logic tk, input string nm);
    cur_op = 7'b1100011; cur_f3 = f3;
    fetch_decode(2'b10, nm);
    step(1, z, 0, mk(S_EXEC, tk ? 7'b0001100 : 7'b0, 2'b01, 2'b10, 0, 0, ret), {nm, "_exec"});
    ret++;
  endtask

  // Monitor: compare whenever a cycle's expectation is pending.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      obs_t e, m;
      string nm;
      e  = exp_q.pop_front();
      nm = nm_q.pop_front();
      m  = care(e);
      check(nm, sample() & m, e & m);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.opcode = '0; bus.funct3 = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;

    // Reset held: everything low, state FETCH.
    step(0, 0, 1, mk(S_FETCH, 7'b0, 2'b00, 2'b00, 0, 0, 0), "reset0");
    step(0, 0, 1, mk(S_FETCH, 7'b0, 2'b00, 2'b00, 0, 0, 0), "reset1");

    // ADD x3,x1,x2 (0x002081B3)
    cur_op = 7'b0110011; cur_f3 = 3'b000;
    fetch_decode(2'b00, "add");
    step(1, 0, 0, mk(S_EXEC, 7'b0, 2'b10, 2'b00, 0, 0, ret), "add_exec");
    step(1, 0, 0, mk(S_WB, 7'b0000010, 2'b00, 2'b00, 0, 0, ret), "add_wb");
    ret++;

    // LW x2,0(x1) (0x0000A103) with three wait cycles in MEM
    cur_op = 7'b0000011; cur_f3 = 3'b010;
    fetch_decode(2'b00, "lw");
    step(1, 0, 0, mk(S_EXEC, 7'b0000001, 2'b00, 2'b00, 0, 0, ret), "lw_exec");
    for (int i = 0; i < 3; i++)
      step(1, 0, 0, mk(S_MEM, 7'b1000000, 2'b00, 2'b00, 0, 0, ret), $sformatf("lw_mem_wait%0d", i));
    step(1, 0, 1, mk(S_MEM, 7'b1000000, 2'b00, 2'b00, 0, 0, ret), "lw_mem_done");
    step(1, 0, 0, mk(S_WB, 7'b0000010, 2'b00, 2'b00, 1, 0, ret), "lw_wb");
    ret++;

    // SW x2,0(x1) (0x0020A023) with one wait cycle
    cur_op = 7'b0100011; cur_f3 = 3'b010;
    fetch_decode(2'b01, "sw");
    step(1, 0, 0, mk(S_EXEC, 7'b0000001, 2'b00, 2'b01, 0, 0, ret), "sw_exec");
    step(1, 0, 0, mk(S_MEM, 7'b0100000, 2'b00, 2'b00, 0, 0, ret), "sw_mem_wait");
    step(1, 0, 1, mk(S_MEM, 7'b0100000, 2'b00, 2'b00, 0, 0, ret), "sw_mem_done");
    ret++;

    // Branches: BEQ/BNE both polarities, and an unsupported funct3.
    branch(3'b000, 1, 1, "beq_taken");
    branch(3'b001, 1, 0, "bne_nottaken");
    branch(3'b001, 0, 1, "bne_taken");
    branch(3'b000, 0, 0, "beq_nottaken");
    branch(3'b100, 1, 0, "f3_100_nottaken");

    // ADDI
    cur_op = 7'b0010011; cur_f3 = 3'b000;
    fetch_decode(2'b00, "addi");
    step(1, 0, 0, mk(S_EXEC, 7'b0000001, 2'b10, 2'b00, 0, 0, ret), "addi_exec");
    step(1, 0, 0, mk(S_WB, 7'b0000010, 2'b00, 2'b00, 0, 0, ret), "addi_wb");
    ret++;

    // Reset in the middle of a SW wait.
    cur_op = 7'b0100011; cur_f3 = 3'b010;
    fetch_decode(2'b01, "swr");
    step(1, 0, 0, mk(S_EXEC, 7'b0000001, 2'b00, 2'b01, 0, 0, ret), "swr_exec");
    step(1, 0, 0, mk(S_MEM, 7'b0100000, 2'b00, 2'b00, 0, 0, ret), "swr_mem_wait");
    ret = 0;
    step(0, 0, 0, mk(S_FETCH, 7'b0, 2'b00, 2'b00, 0, 0, 0), "swr_reset");
    step(1, 0, 0, mk(S_FETCH, 7'b1000000, 2'b00, 2'b00, 0, 0, 0), "swr_after_reset");

    // Illegal opcode 0x7F.
    cur_op = 7'h7F; cur_f3 = 3'b000;
    fetch_decode(2'b00, "ill");
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++)
      step(1, 0, 1, mk(S_TRAP, 7'b0, 2'b00, 2'b00, 0, 1, ret), $sformatf("ill_trap%0d", i));
`else
    ret++;
    step(1, 0, 0, mk(S_FETCH, 7'b1000000, 2'b00, 2'b00, 0, 0, ret), "ill_nop_fetch");
`endif

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, required 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
